// File: rtl/imm_ext_if.sv
// Request/response bundle for the immediate extension pipe.
// The producer side drives requests; the consumer side takes results.
interface imm_ext_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       instr;
    logic              ext_type;
    logic [1:0]        length_in;
    logic [1:0]        scale;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ext_out;
    logic              ovf;

    modport master (
        output in_valid,
        output instr,
        output ext_type,
        output length_in,
        output scale,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  ext_out,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  instr,
        input  ext_type,
        input  length_in,
        input  scale,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output ext_out,
        output ovf
    );
endinterface

// File: rtl/imm_ext_pipe.sv
// Immediate extender: 5/8/11-bit fields, 8-bit prefix combine,
// scale shift with overflow flag, one-deep registered output.
module imm_ext_pipe #(
    parameter int DATA_W = 16
) (
    input  logic     clk,
    input  logic     rst,
    imm_ext_if.slave bus
);
    typedef enum logic {
        IDLE,
        PREFIXED
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        prefix_q, prefix_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] ext_out_q, ext_out_d;
    logic              ovf_q, ovf_d;

    logic              is_len5;
    logic              is_len8;
    logic              is_len11;
    logic              is_pfx;
    logic              accept;
    logic              sgn5;
    logic              sgn8;
    logic              sgn11;
    logic              sgn_pfx;
    logic [DATA_W-1:0] field_ext;
    logic [DATA_W-9:0] pfx_ext;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] shifted;
    logic              lost;
    logic              unused_hi;

    assign unused_hi = ^bus.instr[15:11];

    assign is_len5  = (bus.length_in == 2'b00);
    assign is_len8  = (bus.length_in == 2'b01);
    assign is_len11 = (bus.length_in == 2'b10);
    assign is_pfx   = (bus.length_in == 2'b11);

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

    assign sgn5    = bus.ext_type & bus.instr[4];
    assign sgn8    = bus.ext_type & bus.instr[7];
    assign sgn11   = bus.ext_type & bus.instr[10];
    assign sgn_pfx = bus.ext_type & prefix_q[7];

    always_comb begin
        field_ext = '0;
        unique case (1'b1)
            is_len5: begin
                field_ext = {{(DATA_W-5){sgn5}}, bus.instr[4:0]};
            end
            is_len8: begin
                field_ext = {{(DATA_W-8){sgn8}}, bus.instr[7:0]};
            end
            is_len11: begin
                field_ext = {{(DATA_W-11){sgn11}}, bus.instr[10:0]};
            end
            default: begin
                field_ext = '0;
            end
        endcase
    end

    // Prefix widened to DATA_W-8 so it sits above the field's low byte.
    always_comb begin
        pfx_ext      = {(DATA_W-8){sgn_pfx}};
        pfx_ext[7:0] = prefix_q;
    end

    assign base = (state_q == PREFIXED) ?
                  {pfx_ext, field_ext[7:0]} : field_ext;

    assign shifted = base << bus.scale;

    // Bits pushed out of the top must all match the surviving sign.
    always_comb begin
        lost = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < bus.scale) begin
                if (bus.ext_type) begin
                    lost = lost |
                           (base[DATA_W-1-i] != shifted[DATA_W-1]);
                end else begin
                    lost = lost | base[DATA_W-1-i];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        prefix_d    = prefix_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        ext_out_d   = ext_out_q;
        ovf_d       = ovf_q;
        if (bus.flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else if (accept) begin
            if (is_pfx) begin
                prefix_d = bus.instr[7:0];
                state_d  = PREFIXED;
            end else begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
                ext_out_d   = shifted;
                ovf_d       = lost;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prefix_q    <= '0;
            out_valid_q <= 1'b0;
            ext_out_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prefix_q    <= prefix_d;
            out_valid_q <= out_valid_d;
            ext_out_q   <= ext_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.ext_out   = ext_out_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: vector table through a result scoreboard,
// then backpressure, flush and reset sequences.
module tb_imm_ext_pipe;
    typedef struct packed {
        logic [15:0] eo;
        logic        ov;
    } exp_t;

    typedef struct {
        logic [15:0] instr;
        logic        et;
        logic [1:0]  ln;
        logic [1:0]  sc;
        logic [15:0] eo;
        logic        ov;
    } vec_t;

    localparam int NV = 21;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    exp_t drop_e;
    vec_t vt[NV];

    imm_ext_if #(.DATA_W(16)) bus ();

    imm_ext_pipe #(.DATA_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Results are taken at the negedge ahead of the consuming edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1 &&
            bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_output: got %h expected none",
                         bus.ext_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ext_out", bus.ext_out, mon_e.eo);
                chk("ovf", 16'(bus.ovf), 16'(mon_e.ov));
            end
        end
    end

    task automatic send(input logic [15:0] ins, input logic et,
                        input logic [1:0] ln, input logic [1:0] sc,
                        input logic [15:0] eo, input logic ov);
        int n;
        n = 0;
        bus.in_valid  = 1'b1;
        bus.instr     = ins;
        bus.ext_type  = et;
        bus.length_in = ln;
        bus.scale     = sc;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=%b expected 1",
                     bus.in_ready);
        end else if (ln != 2'b11) begin
            exp_q.push_back({eo, ov});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", 16'(exp_q.size()), 16'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{16'h001F, 1'b1, 2'b00, 2'd0, 16'hFFFF, 1'b0};
        vt[1]  = '{16'h001F, 1'b0, 2'b00, 2'd0, 16'h001F, 1'b0};
        vt[2]  = '{16'h0400, 1'b1, 2'b10, 2'd1, 16'hF800, 1'b0};
        vt[3]  = '{16'hAB12, 1'b0, 2'b11, 2'd0, 16'h0000, 1'b0};
        vt[4]  = '{16'h0034, 1'b0, 2'b01, 2'd0, 16'h1234, 1'b0};
        vt[5]  = '{16'h007F, 1'b0, 2'b11, 2'd0, 16'h0000, 1'b0};
        vt[6]  = '{16'h00FF, 1'b1, 2'b01, 2'd1, 16'hFFFE, 1'b1};
        vt[7]  = '{16'h00FF, 1'b0, 2'b01, 2'd3, 16'h07F8, 1'b0};
        vt[8]  = '{16'hFFFF, 1'b0, 2'b10, 2'd2, 16'h1FFC, 1'b0};
        vt[9]  = '{16'h0080, 1'b0, 2'b11, 2'd0, 16'h0000, 1'b0};
        vt[10] = '{16'h0000, 1'b0, 2'b01, 2'd1, 16'h0000, 1'b1};
        vt[11] = '{16'h0080, 1'b1, 2'b11, 2'd0, 16'h0000, 1'b0};
        vt[12] = '{16'h0001, 1'b1, 2'b01, 2'd2, 16'h0004, 1'b1};
        vt[13] = '{16'h0080, 1'b1, 2'b01, 2'd0, 16'hFF80, 1'b0};
        vt[14] = '{16'h0012, 1'b1, 2'b11, 2'd0, 16'h0000, 1'b0};
        vt[15] = '{16'h001F, 1'b1, 2'b00, 2'd0, 16'h12FF, 1'b0};
        vt[16] = '{16'h0011, 1'b0, 2'b11, 2'd0, 16'h0000, 1'b0};
        vt[17] = '{16'h0022, 1'b0, 2'b11, 2'd0, 16'h0000, 1'b0};
        vt[18] = '{16'h0033, 1'b0, 2'b01, 2'd0, 16'h2233, 1'b0};
        vt[19] = '{16'h000F, 1'b1, 2'b00, 2'd3, 16'h0078, 1'b0};
        vt[20] = '{16'h0010, 1'b1, 2'b00, 2'd3, 16'hFF80, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.instr     = 16'h0000;
        bus.ext_type  = 1'b0;
        bus.length_in = 2'b00;
        bus.scale     = 2'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst_ext_out", bus.ext_out, 16'h0000);
        chk("rst_ovf", 16'(bus.ovf), 16'd0);
        chk("rst_in_ready", 16'(bus.in_ready), 16'd1);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            send(vt[i].instr, vt[i].et, vt[i].ln, vt[i].sc,
                 vt[i].eo, vt[i].ov);
        end
        drain();

        // Stalled consumer: held result, no accept, then resume.
        bus.out_ready = 1'b0;
        send(16'h0034, 1'b0, 2'b01, 2'd0, 16'h0034, 1'b0);
        bus.in_valid  = 1'b1;
        bus.instr     = 16'h0056;
        bus.ext_type  = 1'b0;
        bus.length_in = 2'b01;
        bus.scale     = 2'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 16'(bus.in_ready), 16'd0);
            chk("bp_out_valid", 16'(bus.out_valid), 16'd1);
            chk("bp_hold", bus.ext_out, 16'h0034);
        end
        tick();
        bus.out_ready = 1'b1;
        send(16'h0056, 1'b0, 2'b01, 2'd1, 16'h00AC, 1'b0);
        drain();

        // Flush in PREFIXED drops the request and the prefix state.
        send(16'h0055, 1'b0, 2'b11, 2'd0, 16'h0000, 1'b0);
        bus.in_valid  = 1'b1;
        bus.instr     = 16'h0077;
        bus.length_in = 2'b01;
        bus.flush     = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_out_valid", 16'(bus.out_valid), 16'd0);
        send(16'h0034, 1'b0, 2'b01, 2'd0, 16'h0034, 1'b0);
        drain();

        // Flush discards a stalled result but keeps its value.
        bus.out_ready = 1'b0;
        send(16'h0005, 1'b0, 2'b00, 2'd0, 16'h0005, 1'b0);
        drop_e        = exp_q.pop_back();
        bus.in_valid  = 1'b1;
        bus.instr     = 16'h0006;
        bus.length_in = 2'b00;
        bus.flush     = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl2_out_valid", 16'(bus.out_valid), 16'd0);
        chk("fl2_hold", bus.ext_out, drop_e.eo);
        chk("fl2_in_ready", 16'(bus.in_ready), 16'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("fl2_no_out", 16'(bus.out_valid), 16'd0);

        // Reset with a stalled overflowing result and pending request.
        send(16'h0040, 1'b0, 2'b11, 2'd0, 16'h0000, 1'b0);
        bus.out_ready = 1'b0;
        send(16'h0001, 1'b0, 2'b01, 2'd2, 16'h0004, 1'b1);
        chk("pre_rst_ovf", 16'(bus.ovf), 16'd1);
        drop_e        = exp_q.pop_back();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.flush     = 1'b1;
        bus.instr     = 16'h0003;
        bus.length_in = 2'b00;
        repeat (2) tick();
        chk("rst2_out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst2_ext_out", bus.ext_out, 16'h0000);
        chk("rst2_ovf", 16'(bus.ovf), 16'd0);
        chk("rst2_in_ready", 16'(bus.in_ready), 16'd1);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset while PREFIXED must forget the prefix.
        send(16'h0066, 1'b0, 2'b11, 2'd0, 16'h0000, 1'b0);
        rst = 1'b1;
        repeat (2) tick();
        chk("rst3_out_valid", 16'(bus.out_valid), 16'd0);
        rst = 1'b0;
        send(16'h0034, 1'b0, 2'b01, 2'd0, 16'h0034, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
